// File: rtl/comparator_burst_injector_pkg.sv
// Shared types and default widths for the comparator burst injector slice.
package comptest_pkg;

    localparam int DEF_HS_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH = 32;
    localparam int DEF_BX_WIDTH  = 4;
    localparam int DEF_NP_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE,
        PULSE_ON,
        PULSE_OFF,
        READOUT
    } state_t;

endpackage

// File: rtl/comparator_burst_injector_if.sv
// Control, compare and status bundle between host logic and the burst injector.
interface comparator_burst_injector_if #(
    parameter int HS_WIDTH  = comptest_pkg::DEF_HS_WIDTH,
    parameter int CNT_WIDTH = comptest_pkg::DEF_CNT_WIDTH,
    parameter int BX_WIDTH  = comptest_pkg::DEF_BX_WIDTH,
    parameter int NP_WIDTH  = comptest_pkg::DEF_NP_WIDTH
);
    logic                 fire_pulse;
    logic                 abort;
    logic [NP_WIDTH-1:0]  num_pulses;
    logic [BX_WIDTH-1:0]  pulse_width;
    logic [BX_WIDTH-1:0]  bx_delay;
    logic                 compin_inject;
    logic [HS_WIDTH-1:0]  halfstrips;
    logic [HS_WIDTH-1:0]  halfstrips_expect;
    logic [HS_WIDTH-1:0]  halfstrips_mask;
    logic                 compout;
    logic                 compout_expect;
    logic                 halfstrips_errcnt_rst;
    logic                 compout_errcnt_rst;
    logic                 pulse_en;
    logic                 compin;
    logic                 pulser_ready;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] halfstrips_errcnt;
    logic [CNT_WIDTH-1:0] compout_errcnt;
    logic [CNT_WIDTH-1:0] shots_done;
    logic [HS_WIDTH-1:0]  halfstrips_errbits;
    logic                 compout_last;

    modport slave (
        input  fire_pulse, abort, num_pulses, pulse_width, bx_delay, compin_inject,
               halfstrips, halfstrips_expect, halfstrips_mask, compout, compout_expect,
               halfstrips_errcnt_rst, compout_errcnt_rst,
        output pulse_en, compin, pulser_ready, busy, done, halfstrips_errcnt,
               compout_errcnt, shots_done, halfstrips_errbits, compout_last
    );

    modport master (
        output fire_pulse, abort, num_pulses, pulse_width, bx_delay, compin_inject,
               halfstrips, halfstrips_expect, halfstrips_mask, compout, compout_expect,
               halfstrips_errcnt_rst, compout_errcnt_rst,
        input  pulse_en, compin, pulser_ready, busy, done, halfstrips_errcnt,
               compout_errcnt, shots_done, halfstrips_errbits, compout_last
    );

endinterface

// File: rtl/comparator_burst_injector_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module comparator_sat_counter
    import comptest_pkg::*;
#(
    parameter int WIDTH = DEF_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/comparator_burst_injector.sv
// Fires a burst of test pulses into the comparator front end and checks each readout.
module comparator_burst_injector
    import comptest_pkg::*;
#(
    parameter int HS_WIDTH  = DEF_HS_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int BX_WIDTH  = DEF_BX_WIDTH,
    parameter int NP_WIDTH  = DEF_NP_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    comparator_burst_injector_if.slave  bus
);

    state_t              state_q;
    logic [BX_WIDTH-1:0] timer_q;
    logic [NP_WIDTH-1:0] shots_left_q;
    logic [BX_WIDTH-1:0] w_q;
    logic [BX_WIDTH-1:0] d_q;
    logic                inject_q;
    logic                pulse_en_q;
    logic                compin_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                compout_last_q;
    logic [HS_WIDTH-1:0] errbits_q;

    logic [BX_WIDTH-1:0] w_eff;
    logic [NP_WIDTH-1:0] n_eff;
    logic [HS_WIDTH-1:0] hs_diff;
    logic                readout_upd;

    assign w_eff       = (bus.pulse_width == '0) ? BX_WIDTH'(1) : bus.pulse_width;
    assign n_eff       = (bus.num_pulses == '0) ? NP_WIDTH'(1) : bus.num_pulses;
    assign hs_diff     = (bus.halfstrips ^ bus.halfstrips_expect) & bus.halfstrips_mask;
    assign readout_upd = (state_q == READOUT) && !bus.abort;

    // Timer counts down the cycles left in the current phase; outputs are set
    // on the transition edge so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            shots_left_q <= '0;
            w_q          <= '0;
            d_q          <= '0;
            inject_q     <= 1'b0;
            pulse_en_q   <= 1'b0;
            compin_q     <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort && (state_q != IDLE)) begin
                state_q    <= IDLE;
                pulse_en_q <= 1'b0;
                compin_q   <= 1'b0;
                ready_q    <= 1'b1;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.fire_pulse) begin
                            state_q      <= PULSE_ON;
                            shots_left_q <= n_eff;
                            w_q          <= w_eff;
                            d_q          <= bus.bx_delay;
                            inject_q     <= bus.compin_inject;
                            timer_q      <= w_eff - BX_WIDTH'(1);
                            pulse_en_q   <= 1'b1;
                            compin_q     <= bus.compin_inject;
                            ready_q      <= 1'b0;
                            busy_q       <= 1'b1;
                        end
                    end
                    PULSE_ON: begin
                        if (timer_q == '0) begin
                            pulse_en_q <= 1'b0;
                            compin_q   <= 1'b0;
                            if (d_q == '0) begin
                                state_q <= READOUT;
                            end else begin
                                state_q <= PULSE_OFF;
                                timer_q <= d_q - BX_WIDTH'(1);
                            end
                        end else begin
                            timer_q <= timer_q - BX_WIDTH'(1);
                        end
                    end
                    PULSE_OFF: begin
                        if (timer_q == '0) begin
                            state_q <= READOUT;
                        end else begin
                            timer_q <= timer_q - BX_WIDTH'(1);
                        end
                    end
                    READOUT: begin
                        shots_left_q <= shots_left_q - NP_WIDTH'(1);
                        if (shots_left_q > NP_WIDTH'(1)) begin
                            state_q    <= PULSE_ON;
                            timer_q    <= w_q - BX_WIDTH'(1);
                            pulse_en_q <= 1'b1;
                            compin_q   <= inject_q;
                        end else begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errbits_q      <= '0;
            compout_last_q <= 1'b0;
        end else begin
            if (bus.halfstrips_errcnt_rst) begin
                errbits_q <= '0;
            end else if (readout_upd) begin
                errbits_q <= errbits_q | hs_diff;
            end
            if (readout_upd) begin
                compout_last_q <= bus.compout;
            end
        end
    end

    comparator_sat_counter #(.WIDTH(CNT_WIDTH)) u_hs_errcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.halfstrips_errcnt_rst),
        .inc   (readout_upd && (|hs_diff)),
        .q     (bus.halfstrips_errcnt)
    );

    comparator_sat_counter #(.WIDTH(CNT_WIDTH)) u_co_errcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.compout_errcnt_rst),
        .inc   (readout_upd && (bus.compout != bus.compout_expect)),
        .q     (bus.compout_errcnt)
    );

    comparator_sat_counter #(.WIDTH(CNT_WIDTH)) u_shots (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.halfstrips_errcnt_rst),
        .inc   (readout_upd),
        .q     (bus.shots_done)
    );

    assign bus.pulse_en           = pulse_en_q;
    assign bus.compin             = compin_q;
    assign bus.pulser_ready       = ready_q;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.halfstrips_errbits = errbits_q;
    assign bus.compout_last       = compout_last_q;

endmodule

// File: tb/tb_comparator_burst_injector.sv
// Self-checking bench: two injectors (32-bit and 2-bit counters) against a shot-level model.
module tb_comparator_burst_injector;

    localparam longint MAX_M = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX_S = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comparator_burst_injector_if #(.HS_WIDTH(32), .CNT_WIDTH(32), .BX_WIDTH(4), .NP_WIDTH(16)) bus ();
    comparator_burst_injector_if #(.HS_WIDTH(32), .CNT_WIDTH(2),  .BX_WIDTH(4), .NP_WIDTH(16)) sbus ();

    assign sbus.fire_pulse            = bus.fire_pulse;
    assign sbus.abort                 = bus.abort;
    assign sbus.num_pulses            = bus.num_pulses;
    assign sbus.pulse_width           = bus.pulse_width;
    assign sbus.bx_delay              = bus.bx_delay;
    assign sbus.compin_inject         = bus.compin_inject;
    assign sbus.halfstrips            = bus.halfstrips;
    assign sbus.halfstrips_expect     = bus.halfstrips_expect;
    assign sbus.halfstrips_mask       = bus.halfstrips_mask;
    assign sbus.compout               = bus.compout;
    assign sbus.compout_expect        = bus.compout_expect;
    assign sbus.halfstrips_errcnt_rst = bus.halfstrips_errcnt_rst;
    assign sbus.compout_errcnt_rst    = bus.compout_errcnt_rst;

    comparator_burst_injector #(.HS_WIDTH(32), .CNT_WIDTH(32), .BX_WIDTH(4), .NP_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    comparator_burst_injector #(.HS_WIDTH(32), .CNT_WIDTH(2), .BX_WIDTH(4), .NP_WIDTH(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    int checks = 0;
    int errors = 0;

    // Shot-level reference model state
    longint      m_hs, m_co, m_shots, m_hs_s, m_co_s, m_shots_s;
    logic [31:0] m_bits;
    logic        m_last;

    logic [31:0] hse_v, mask_v;
    logic        coe_v;
    logic [31:0] s_hs [16];
    logic        s_co [16];

    function automatic longint sat_inc(input longint v, input longint lim);
        return (v >= lim) ? lim : v + 1;
    endfunction

    task automatic model_zero();
        m_hs = 0; m_co = 0; m_shots = 0; m_hs_s = 0; m_co_s = 0; m_shots_s = 0;
        m_bits = '0; m_last = 1'b0;
    endtask

    task automatic model_readout(input logic [31:0] hs, input logic co, input bit upd, input bit clr);
        logic [31:0] diff;
        diff = (hs ^ hse_v) & mask_v;
        if (clr) begin
            m_hs = 0; m_hs_s = 0; m_bits = '0; m_shots = 0; m_shots_s = 0;
        end else if (upd) begin
            if (diff != 0) begin
                m_hs   = sat_inc(m_hs, MAX_M);
                m_hs_s = sat_inc(m_hs_s, MAX_S);
            end
            m_bits    = m_bits | diff;
            m_shots   = sat_inc(m_shots, MAX_M);
            m_shots_s = sat_inc(m_shots_s, MAX_S);
        end
        if (upd && (co !== coe_v)) begin
            m_co   = sat_inc(m_co, MAX_M);
            m_co_s = sat_inc(m_co_s, MAX_S);
        end
        if (upd) m_last = co;
    endtask

    // Drives one burst and checks every cycle from the first pulse cycle to two past the end.
    task automatic run_burst(input int n_cfg, input int w_cfg, input int d_cfg, input bit inj,
                             input int abort_cyc, input int fire_mid_cyc, input int clr_shot);
        int neff, weff, p, total, t, shot;
        bit active, pulse, done_e, is_ro;
        logic [9:0]  ctrl_a, ctrl_e;
        logic [95:0] cnt_a, cnt_e;
        logic [5:0]  scnt_a, scnt_e;
        logic [65:0] bits_a, bits_e;
        neff  = (n_cfg == 0) ? 1 : n_cfg;
        weff  = (w_cfg == 0) ? 1 : w_cfg;
        p     = weff + d_cfg + 1;
        total = neff * p;
        @(negedge clk);
        bus.halfstrips_expect = hse_v;
        bus.halfstrips_mask   = mask_v;
        bus.compout_expect    = coe_v;
        bus.num_pulses        = 16'(n_cfg);
        bus.pulse_width       = 4'(w_cfg);
        bus.bx_delay          = 4'(d_cfg);
        bus.compin_inject     = inj;
        bus.fire_pulse        = 1'b1;
        for (int n = 1; n <= total + 2; n++) begin
            @(negedge clk);
            bus.fire_pulse = 1'b0;
            bus.abort = 1'b0;
            bus.halfstrips_errcnt_rst = 1'b0;
            if (n == 1) begin
                bus.num_pulses    = 16'($urandom);
                bus.pulse_width   = 4'($urandom);
                bus.bx_delay      = 4'($urandom);
                bus.compin_inject = ~inj;
            end
            active = (n <= total) && (abort_cyc == 0 || n <= abort_cyc);
            t      = (n - 1) % p;
            shot   = (n - 1) / p;
            pulse  = active && (t < weff);
            done_e = (abort_cyc == 0) && (n == total + 1);
            ctrl_e = {2{pulse, pulse && inj, active, !active, done_e}};
            ctrl_a = {bus.pulse_en, bus.compin, bus.busy, bus.pulser_ready, bus.done,
                      sbus.pulse_en, sbus.compin, sbus.busy, sbus.pulser_ready, sbus.done};
            checks++;
            if (ctrl_a !== ctrl_e) begin
                errors++;
                $display("FAIL ctrl cyc %0d got %b exp %b (pulse_en,compin,busy,ready,done x2)", n, ctrl_a, ctrl_e);
            end
            cnt_e = {32'(m_hs), 32'(m_co), 32'(m_shots)};
            cnt_a = {bus.halfstrips_errcnt, bus.compout_errcnt, bus.shots_done};
            checks++;
            if (cnt_a !== cnt_e) begin
                errors++;
                $display("FAIL counters cyc %0d got %h exp %h (hs,co,shots)", n, cnt_a, cnt_e);
            end
            scnt_e = {2'(m_hs_s), 2'(m_co_s), 2'(m_shots_s)};
            scnt_a = {sbus.halfstrips_errcnt, sbus.compout_errcnt, sbus.shots_done};
            checks++;
            if (scnt_a !== scnt_e) begin
                errors++;
                $display("FAIL sat_counters cyc %0d got %b exp %b (hs,co,shots 2-bit)", n, scnt_a, scnt_e);
            end
            bits_e = {m_bits, m_last, m_bits, m_last};
            bits_a = {bus.halfstrips_errbits, bus.compout_last, sbus.halfstrips_errbits, sbus.compout_last};
            checks++;
            if (bits_a !== bits_e) begin
                errors++;
                $display("FAIL errbits_last cyc %0d got %h exp %h", n, bits_a, bits_e);
            end
            if (n == abort_cyc) bus.abort = 1'b1;
            if (n == fire_mid_cyc) begin
                bus.fire_pulse  = 1'b1;
                bus.num_pulses  = 16'($urandom);
                bus.pulse_width = 4'($urandom);
            end
            is_ro = active && (t == p - 1);
            if (is_ro) begin
                bus.halfstrips = s_hs[shot];
                bus.compout    = s_co[shot];
                bus.halfstrips_errcnt_rst = (shot == clr_shot);
                model_readout(s_hs[shot], s_co[shot], n != abort_cyc, shot == clr_shot);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fire_pulse = 0; bus.abort = 0; bus.num_pulses = '0; bus.pulse_width = '0;
        bus.bx_delay = '0; bus.compin_inject = 0; bus.halfstrips = '0; bus.halfstrips_expect = '0;
        bus.halfstrips_mask = '0; bus.compout = 0; bus.compout_expect = 0;
        bus.halfstrips_errcnt_rst = 0; bus.compout_errcnt_rst = 0;
        model_zero();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.pulse_en, bus.compin, bus.busy, bus.pulser_ready, bus.done} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00010", {bus.pulse_en, bus.compin, bus.busy, bus.pulser_ready, bus.done});
        end
        checks++;
        if ({bus.halfstrips_errcnt, bus.compout_errcnt, bus.shots_done, bus.halfstrips_errbits, bus.compout_last} !== '0) begin
            errors++;
            $display("FAIL reset_counters got %h exp 0",
                     {bus.halfstrips_errcnt, bus.compout_errcnt, bus.shots_done, bus.halfstrips_errbits, bus.compout_last});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_shot();
        test_reset();
        hse_v = 32'hCAFE_0123; mask_v = '1; coe_v = 1'b1;
        s_hs[0] = hse_v; s_co[0] = 1'b1;
        run_burst(1, 3, 2, 1'b1, 0, 0, -1);
        checks++;
        if ({bus.shots_done, bus.halfstrips_errcnt, bus.compout_errcnt} !== {32'd1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL single_shot got %h exp shots=1 errs=0", {bus.shots_done, bus.halfstrips_errcnt, bus.compout_errcnt});
        end
    endtask

    task automatic test_burst_compout();
        test_reset();
        hse_v = 32'h0F0F_0F0F; mask_v = '1; coe_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_hs[k] = hse_v;
            s_co[k] = (k % 2 == 1);
        end
        run_burst(4, 1, 0, 1'b1, 0, 0, -1);
        checks++;
        if ({bus.compout_errcnt, bus.shots_done} !== {32'd2, 32'd4}) begin
            errors++;
            $display("FAIL burst_compout got %h exp co=2 shots=4", {bus.compout_errcnt, bus.shots_done});
        end
    endtask

    task automatic test_masked();
        test_reset();
        hse_v = 32'h1234_5678; mask_v = 32'h0000_0100; coe_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_hs[k] = hse_v ^ 32'h0000_0101;
            s_co[k] = 1'b0;
        end
        run_burst(3, 2, 1, 1'b1, 0, 0, -1);
        checks++;
        if ({bus.halfstrips_errcnt, bus.halfstrips_errbits} !== {32'd3, 32'h0000_0100}) begin
            errors++;
            $display("FAIL masked got %h exp cnt=3 bits=00000100", {bus.halfstrips_errcnt, bus.halfstrips_errbits});
        end
    endtask

    task automatic test_saturation();
        test_reset();
        hse_v = 32'h0; mask_v = '1; coe_v = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_hs[k] = 32'h8000_0001;
            s_co[k] = 1'b1;
        end
        run_burst(6, 1, 1, 1'b0, 0, 0, 4);
        checks++;
        if ({sbus.halfstrips_errcnt, sbus.compout_errcnt, sbus.shots_done} !== {2'd1, 2'd3, 2'd1}) begin
            errors++;
            $display("FAIL saturation got %b exp hs=01 co=11 shots=01",
                     {sbus.halfstrips_errcnt, sbus.compout_errcnt, sbus.shots_done});
        end
    endtask

    task automatic test_abort();
        test_reset();
        hse_v = 32'hA5A5_A5A5; mask_v = '1; coe_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_hs[k] = hse_v;
            s_co[k] = 1'b1;
        end
        run_burst(3, 2, 3, 1'b1, 10, 4, -1);
        checks++;
        if ({bus.shots_done, bus.busy} !== {32'd1, 1'b0}) begin
            errors++;
            $display("FAIL abort got %h exp shots=1 busy=0", {bus.shots_done, bus.busy});
        end
    endtask

    task automatic test_no_inject_and_reset();
        test_reset();
        hse_v = 32'h0; mask_v = '1; coe_v = 1'b0;
        s_hs[0] = 32'h4; s_hs[1] = 32'h0; s_co[0] = 1'b1; s_co[1] = 1'b0;
        run_burst(2, 2, 1, 1'b0, 0, 0, -1);
        @(negedge clk);
        bus.pulse_width = 4'd3; bus.num_pulses = 16'd2; bus.compin_inject = 1'b1;
        bus.fire_pulse = 1'b1;
        @(negedge clk);
        bus.fire_pulse = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.pulse_en, bus.compin} !== 2'b11) begin
            errors++;
            $display("FAIL mid_pulse got %b exp 11", {bus.pulse_en, bus.compin});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.pulse_en, bus.compin, bus.busy, bus.pulser_ready, bus.done, bus.halfstrips_errcnt,
             bus.compout_errcnt, bus.shots_done, bus.halfstrips_errbits, bus.compout_last} !== {5'b00010, 129'd0}) begin
            errors++;
            $display("FAIL async_reset got ctrl=%b hs=%0d co=%0d shots=%0d bits=%h",
                     {bus.pulse_en, bus.compin, bus.busy, bus.pulser_ready, bus.done},
                     bus.halfstrips_errcnt, bus.compout_errcnt, bus.shots_done, bus.halfstrips_errbits);
        end
        model_zero();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clears();
        test_reset();
        hse_v = 32'h0; mask_v = 32'hFF; coe_v = 1'b0;
        s_hs[0] = 32'h3; s_hs[1] = 32'h10; s_co[0] = 1'b1; s_co[1] = 1'b1;
        run_burst(2, 1, 2, 1'b1, 0, 0, -1);
        @(negedge clk);
        bus.compout_errcnt_rst = 1'b1;
        @(negedge clk);
        bus.compout_errcnt_rst = 1'b0;
        checks++;
        if ({bus.compout_errcnt, bus.halfstrips_errcnt, bus.shots_done, bus.halfstrips_errbits} !==
            {32'd0, 32'd2, 32'd2, 32'h13}) begin
            errors++;
            $display("FAIL co_clear got %h exp co=0 hs=2 shots=2 bits=13",
                     {bus.compout_errcnt, bus.halfstrips_errcnt, bus.shots_done, bus.halfstrips_errbits});
        end
        bus.halfstrips_errcnt_rst = 1'b1;
        @(negedge clk);
        bus.halfstrips_errcnt_rst = 1'b0;
        checks++;
        if ({bus.halfstrips_errcnt, bus.shots_done, bus.halfstrips_errbits, bus.compout_last} !== {96'd0, 1'b1}) begin
            errors++;
            $display("FAIL hs_clear got %h exp hs/shots/bits=0 last=1",
                     {bus.halfstrips_errcnt, bus.shots_done, bus.halfstrips_errbits, bus.compout_last});
        end
        m_co = 0; m_co_s = 0;
        model_readout('0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int n, w, d, neff, total, ab, fm, cs;
        test_reset();
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(0, 5);
            w = $urandom_range(0, 4);
            d = $urandom_range(0, 3);
            neff  = (n == 0) ? 1 : n;
            total = neff * (((w == 0) ? 1 : w) + d + 1);
            hse_v  = $urandom;
            mask_v = $urandom;
            coe_v  = 1'($urandom_range(0, 1));
            for (int k = 0; k < 16; k++) begin
                s_hs[k] = ($urandom_range(0, 1) == 1) ? hse_v : hse_v ^ $urandom;
                s_co[k] = 1'($urandom_range(0, 1));
            end
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total)) : 0;
            fm = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (ab != 0) ? ab : total)) : 0;
            cs = (ab == 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, neff - 1)) : -1;
            run_burst(n, w, d, 1'($urandom_range(0, 1)), ab, fm, cs);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_burst_compout();
        test_masked();
        test_saturation();
        test_abort();
        test_no_inject_and_reset();
        test_clears();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
